// File: rtl/q_stream_monitor.sv
// Stream checker for the 4-bit register stage. It checks that q and qnot are complementary,
// detects a programmable 3-value sequence on q, and reports each match as a timestamped event.
module q_stream_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] qnot_in,
  input  logic [WIDTH-1:0] pat0,
  input  logic [WIDTH-1:0] pat1,
  input  logic [WIDTH-1:0] pat2,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             err,
  output logic             err_flag,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_data,
  output logic             ovf_flag
);

  // state  | meaning
  // S_IDLE | no prefix of the pattern seen
  // S_GOT0 | last valid sample matched pat0
  // S_GOT1 | last two valid samples matched pat0, pat1
  typedef enum logic [1:0] {S_IDLE, S_GOT0, S_GOT1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             match_q, err_q, err_flag_q, ovf_q, evt_valid_q;
  logic             err_flag_d, ovf_d, evt_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, ts_q, evt_data_q, evt_data_d;
  logic             sample_ok, sample_bad, hit, accept;

  assign sample_ok  = en && (q_in == ~qnot_in);
  assign sample_bad = en && (q_in != ~qnot_in);
  assign accept     = evt_valid_q && evt_ready;

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (sample_bad) begin
      state_d = S_IDLE;
    end else if (sample_ok) begin
      case (state_q)
        S_IDLE: state_d = (q_in == pat0) ? S_GOT0 : S_IDLE;
        S_GOT0: begin
          if (q_in == pat1)      state_d = S_GOT1;
          else if (q_in == pat0) state_d = S_GOT0;
          else                   state_d = S_IDLE;
        end
        S_GOT1: begin
          if (q_in == pat2) begin
            hit     = 1'b1;
            // a completed match can double as the start of the next one
            state_d = (pat2 == pat0) ? S_GOT0 : S_IDLE;
          end else if (q_in == pat0) begin
            state_d = S_GOT0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    err_flag_d  = err_flag_q | sample_bad;
    ovf_d       = ovf_q | (hit && evt_valid_q && !evt_ready);
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    if (hit && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    if (clr) begin
      cnt_d      = '0;
      err_flag_d = 1'b0;
      ovf_d      = 1'b0;
    end
    // an accept frees the slot in time for a same-cycle match to load
    if (hit && (!evt_valid_q || accept)) begin
      evt_valid_d = 1'b1;
      evt_data_d  = ts_q;
    end else if (accept) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      err_flag_q  <= 1'b0;
      ovf_q       <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      cnt_q       <= '0;
      ts_q        <= '0;
    end else begin
      state_q     <= state_d;
      match_q     <= hit;
      err_q       <= sample_bad;
      err_flag_q  <= err_flag_d;
      ovf_q       <= ovf_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      cnt_q       <= cnt_d;
      ts_q        <= ts_q + CNT_W'(1);
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign err         = err_q;
  assign err_flag    = err_flag_q;
  assign ovf_flag    = ovf_q;
  assign evt_valid   = evt_valid_q;
  assign evt_data    = evt_data_q;

endmodule
